// File: rtl/mmio_dispatch_pkg.sv
// Shared constants and types for the MMIO dispatcher: select codes,
// control-register offsets and the access FSM state encoding.
package mmio_dispatch_pkg;
  localparam logic [7:0] SEL_RAM  = 8'h00;
  localparam logic [7:0] SEL_CTRL = 8'hFF;
  localparam int SEL_LSB       = 16;
  localparam int CTRL_OFS_EN   = 0;
  localparam int CTRL_OFS_PEND = 1;

  typedef enum logic [1:0] {IDLE, RAM_WAIT, RESP} state_t;
endpackage

// File: rtl/mmio_channel_reg.sv
// One peripheral channel: sample holding register plus sticky pending flag.
module mmio_channel_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strobe,
  input  logic [DATA_W-1:0] data,
  input  logic              rd_clr,
  input  logic              w1c,
  output logic [DATA_W-1:0] hold,
  output logic              pending
);
  always_ff @(posedge clk) begin
    if (rst) begin
      hold    <= '0;
      pending <= 1'b0;
    end else begin
      if (strobe) hold <= data;
      // a new sample outranks any clear arriving in the same cycle
      if (strobe)              pending <= 1'b1;
      else if (rd_clr || w1c)  pending <= 1'b0;
    end
  end
endmodule

// File: rtl/mmio_dispatch.sv
// Core load/store dispatcher: decodes the select byte, routes to RAM, channel
// holding registers or control, and returns one response per accepted request.
module mmio_dispatch
  import mmio_dispatch_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 24,
  parameter int RAM_AW  = 15,
  parameter int RAM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     req_ready,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [RAM_AW-1:0]        ram_addr,
  output logic                     ram_we,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_strobe,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic                     irq
);
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] sel;
  logic is_ctrl, is_ch, is_ram, accept;
  logic [NUM_CH-1:0] rd_ch, w1c, pending, irq_en;
  logic [NUM_CH-1:0][DATA_W-1:0] hold;
  logic [DATA_W-1:0] reg_rdata, rdata_d;
  logic rdata_ld;

  assign sel     = req_addr[SEL_LSB +: 8];
  assign is_ctrl = (sel == SEL_CTRL);
  assign is_ch   = (sel != SEL_RAM) && (sel <= 8'(NUM_CH));
  // unmapped selects fall through to RAM
  assign is_ram  = !is_ctrl && !is_ch;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);
  assign ram_addr  = req_addr[RAM_AW-1:0];
  assign ram_wdata = req_wdata;
  assign ram_we    = accept && req_we && is_ram;

  assign w1c = (accept && req_we && is_ctrl && req_addr[0] == 1'(CTRL_OFS_PEND))
             ? req_wdata[NUM_CH-1:0] : '0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign rd_ch[i] = accept && !req_we && (sel == 8'(i + 1));
    mmio_channel_reg #(.DATA_W(DATA_W)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .strobe  (ch_strobe[i]),
      .data    (ch_data[i*DATA_W +: DATA_W]),
      .rd_clr  (rd_ch[i]),
      .w1c     (w1c[i]),
      .hold    (hold[i]),
      .pending (pending[i])
    );
  end

  always_comb begin
    reg_rdata = '0;
    if (is_ctrl) begin
      if (req_addr[0] == 1'(CTRL_OFS_EN)) reg_rdata[NUM_CH-1:0] = irq_en;
      else                                reg_rdata[NUM_CH-1:0] = pending;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (sel == 8'(i + 1)) reg_rdata = hold[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_ld = 1'b0;
    rdata_d  = '0;
    case (state_q)
      IDLE: if (accept) begin
        if (!req_we && is_ram) begin
          state_d = RAM_WAIT;
          cnt_d   = 2'(RAM_LAT - 1);
        end else begin
          state_d  = RESP;
          rdata_ld = 1'b1;
          rdata_d  = req_we ? '0 : reg_rdata;
        end
      end
      RAM_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d  = RESP;
          rdata_ld = 1'b1;
          rdata_d  = ram_rdata;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rsp_rdata <= '0;
      ch_ack    <= '0;
      irq_en    <= '0;
      irq       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (rdata_ld) rsp_rdata <= rdata_d;
      ch_ack  <= rd_ch;
      irq     <= |(pending & irq_en);
      if (accept && req_we && is_ctrl && req_addr[0] == 1'(CTRL_OFS_EN))
        irq_en <= req_wdata[NUM_CH-1:0];
    end
  end
endmodule

// File: tb/tb_mmio_dispatch.sv
// Directed bench for mmio_dispatch with RAM_LAT=2 and a behavioural RAM.
module tb_mmio_dispatch;
  localparam int NUM_CH = 4, DATA_W = 16, ADDR_W = 24, RAM_AW = 15, RAM_LAT = 2;

  logic clk, rst, req_valid, req_we, req_ready, rsp_valid, ram_we, irq;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata, rsp_rdata, ram_wdata, ram_rdata;
  logic [RAM_AW-1:0] ram_addr;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0] ch_strobe, ch_ack;

  int checks = 0, failures = 0;

  mmio_dispatch #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                  .RAM_AW(RAM_AW), .RAM_LAT(RAM_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ch_data(ch_data), .ch_strobe(ch_strobe), .ch_ack(ch_ack), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data for address cycle T appears in T+RAM_LAT
  logic [DATA_W-1:0] mem [0:(1<<RAM_AW)-1];
  logic [DATA_W-1:0] pipe0, pipe1;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    pipe0 <= mem[ram_addr];
    pipe1 <= pipe0;
  end
  assign ram_rdata = pipe1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 of the accept cycle; returns at posedge+1 after the response.
  task automatic xact(input logic we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wd, output logic [DATA_W-1:0] rd,
                      output int lat, output logic [NUM_CH-1:0] ack,
                      output logic we_seen, output logic [RAM_AW-1:0] a_seen);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    chk("accept_ready", req_ready, 1'b1);
    we_seen = ram_we; a_seen = ram_addr;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; ch_strobe = '0;
    lat = -1; rd = '0; ack = '0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i; rd = rsp_rdata; ack = ch_ack;
        chk("rsp_not_ready", req_ready, 1'b0);
        break;
      end
      chk("busy_not_ready", req_ready, 1'b0);
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic strobe(input int ch, input logic [DATA_W-1:0] d);
    ch_strobe[ch] = 1'b1;
    ch_data[ch*DATA_W +: DATA_W] = d;
    @(posedge clk); #1;
    ch_strobe = '0;
  endtask

  logic [DATA_W-1:0] rd;
  int lat;
  logic [NUM_CH-1:0] ack;
  logic wes;
  logic [RAM_AW-1:0] as;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    ch_data = '0; ch_strobe = '0;
    repeat (3) @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rdata", rsp_rdata, 16'h0);
    chk("rst_ack", ch_ack, 4'h0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("first_ready", req_ready, 1'b1);
    @(posedge clk); #1;

    // RAM write then read back
    xact(1'b1, 24'h000123, 16'hBEEF, rd, lat, ack, wes, as);
    chk("wr_ram_we", wes, 1'b1);
    chk("wr_ram_addr", as, 15'h0123);
    chk("wr_lat", lat, 1);
    chk("wr_rdata", rd, 16'h0);
    xact(1'b0, 24'h000123, 16'h0, rd, lat, ack, wes, as);
    chk("rd_ram_we", wes, 1'b0);
    chk("rd_lat", lat, 3);
    chk("rd_data", rd, 16'hBEEF);

    // irq enable on channel 1, then sample and read it
    xact(1'b1, 24'hFF0000, 16'h0002, rd, lat, ack, wes, as);
    chk("en_ram_we", wes, 1'b0);
    chk("irq_idle", irq, 1'b0);
    strobe(1, 16'h00A5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("irq_rise", irq, 1'b1);
    @(posedge clk); #1;
    xact(1'b0, 24'h020000, 16'h0, rd, lat, ack, wes, as);
    chk("ch1_data", rd, 16'h00A5);
    chk("ch1_lat", lat, 1);
    chk("ch1_ack", ack, 4'b0010);
    @(negedge clk);
    chk("irq_fall", irq, 1'b0);
    @(posedge clk); #1;
    xact(1'b0, 24'hFF0001, 16'h0, rd, lat, ack, wes, as);
    chk("pend_after_rd", rd, 16'h0);
    chk("ctrl_no_ack", ack, 4'h0);
    xact(1'b0, 24'hFF0000, 16'h0, rd, lat, ack, wes, as);
    chk("irq_en_rd", rd, 16'h0002);

    // strobe and read of the same channel in one cycle
    strobe(0, 16'h1111);
    ch_strobe[0] = 1'b1; ch_data[15:0] = 16'h2222;
    xact(1'b0, 24'h010000, 16'h0, rd, lat, ack, wes, as);
    chk("ch0_old", rd, 16'h1111);
    chk("ch0_ack", ack, 4'b0001);
    xact(1'b0, 24'hFF0001, 16'h0, rd, lat, ack, wes, as);
    chk("ch0_pend_kept", rd, 16'h0001);
    xact(1'b0, 24'h010000, 16'h0, rd, lat, ack, wes, as);
    chk("ch0_new", rd, 16'h2222);

    // W1C on pending
    ch_strobe = 4'b0101; ch_data = {16'h0, 16'h3333, 16'h0, 16'h4444};
    @(posedge clk); #1; ch_strobe = '0;
    xact(1'b1, 24'hFF0001, 16'h0001, rd, lat, ack, wes, as);
    xact(1'b0, 24'hFF0001, 16'h0, rd, lat, ack, wes, as);
    chk("w1c_pend", rd, 16'h0004);
    ch_strobe[2] = 1'b1;
    xact(1'b1, 24'hFF0001, 16'h0004, rd, lat, ack, wes, as);
    xact(1'b0, 24'hFF0001, 16'h0, rd, lat, ack, wes, as);
    chk("w1c_set_wins", rd, 16'h0004);

    // unmapped selects alias to RAM
    xact(1'b1, 24'h370055, 16'h5A5A, rd, lat, ack, wes, as);
    chk("alias_we", wes, 1'b1);
    chk("alias_addr", as, 15'h0055);
    xact(1'b0, 24'h000055, 16'h0, rd, lat, ack, wes, as);
    chk("alias_rd", rd, 16'h5A5A);
    xact(1'b0, 24'h050055, 16'h0, rd, lat, ack, wes, as);
    chk("sel5_ram_rd", rd, 16'h5A5A);
    chk("sel5_lat", lat, 3);

    // channel writes are ignored but acknowledged
    xact(1'b1, 24'h030000, 16'hFFFF, rd, lat, ack, wes, as);
    chk("chwr_no_ram", wes, 1'b0);
    chk("chwr_lat", lat, 1);
    xact(1'b0, 24'h030000, 16'h0, rd, lat, ack, wes, as);
    chk("chwr_hold", rd, 16'h3333);
    chk("ch2_ack", ack, 4'b0100);

    // reset while a RAM read is outstanding
    req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h000123;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", req_ready, 1'b0);
    chk("mid_rst_rsp", rsp_valid, 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rsp", rsp_valid, 1'b0);
    chk("post_rst_ready", req_ready, 1'b1);
    chk("post_rst_rdata", rsp_rdata, 16'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_rsp2", rsp_valid, 1'b0);
    @(posedge clk); #1;
    xact(1'b0, 24'h000123, 16'h0, rd, lat, ack, wes, as);
    chk("post_rst_rd", rd, 16'hBEEF);
    chk("post_rst_lat", lat, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
